// File: rtl/arb_pkg.sv
// Shared types for the two-master memory bus arbiter: grant state encoding
// doubles as the value presented on the owner debug port.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/rd_return_reg.sv
// Per-master read return: captures memory read data on a read transfer and
// raises a one-cycle valid pulse in the following cycle.
module rd_return_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single memory port, with a bounded
// hold under contention and registered per-master read-data return.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

    arb_state_t        state, state_nxt;
    logic              last_owner;  // 0: M0 was granted last, 1: M1
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_limit;
    logic              owner_xfer;

    assign m0_gnt     = (state == GRANT0);
    assign m1_gnt     = (state == GRANT1);
    assign owner      = state;
    assign owner_xfer = (m0_gnt && m0_req) || (m1_gnt && m1_req);
    // A count saturated while uncontested must still yield once the other master asks.
    assign hold_limit = (hold_cnt == HOLD_LAST) || (hold_cnt == HOLD_MAX);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt = last_owner ? GRANT0 : GRANT1;
                end else if (m0_req) begin
                    state_nxt = GRANT0;
                end else if (m1_req) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_req) begin
                    state_nxt = m1_req ? GRANT1 : IDLE;
                end else if (m1_req && hold_limit) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT1: begin
                if (!m1_req) begin
                    state_nxt = m0_req ? GRANT0 : IDLE;
                end else if (m0_req && hold_limit) begin
                    state_nxt = GRANT0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                hold_cnt <= '0;
                if (state_nxt == GRANT0) begin
                    last_owner <= 1'b0;
                end else if (state_nxt == GRANT1) begin
                    last_owner <= 1'b1;
                end
            end else if (owner_xfer && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_req && m0_we;
        end else if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_req && m1_we;
        end
    end

    rd_return_reg #(
        .DATA_W (DATA_W)
    ) u_rd0 (
        .clk       (clk),
        .reset     (reset),
        .capture   (m0_gnt && m0_req && !m0_we),
        .mem_rdata (mem_rdata),
        .rdata     (m0_rdata),
        .rvalid    (m0_rvalid)
    );

    rd_return_reg #(
        .DATA_W (DATA_W)
    ) u_rd1 (
        .clk       (clk),
        .reset     (reset),
        .capture   (m1_gnt && m1_req && !m1_we),
        .mem_rdata (mem_rdata),
        .rdata     (m1_rdata),
        .rvalid    (m1_rvalid)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed per-cycle expectations are
// queued by the stimulus and popped by an independent negedge monitor.
module tb_mem_bus_arbiter;
    import arb_pkg::*;

    logic       clk;
    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic [1:0] owner;

    // Second instance with MAX_HOLD=1 for the alternate-every-cycle case
    logic       b_r0, b_r1;
    logic       b_g0, b_g1, b_v0, b_v1, b_we;
    logic [7:0] b_rd0, b_rd1, b_addr, b_wdata;
    logic [1:0] b_owner;

    logic [7:0] mem [256];
    bit         mem_init;

    typedef struct {
        logic [1:0] own;
        logic       g0, g1, v0, v1, we;
        logic [7:0] addr, wdata;
        logic [1:0] bown;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] rd0_q [$];
    logic [7:0] rd1_q [$];
    logic [1:0] exp_bown;
    int         n_checks;
    int         n_fail;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(1)) dut_h1 (
        .clk(clk), .reset(reset),
        .m0_req(b_r0), .m0_we(1'b0), .m0_addr(8'h00), .m0_wdata(8'h00),
        .m0_gnt(b_g0), .m0_rdata(b_rd0), .m0_rvalid(b_v0),
        .m1_req(b_r1), .m1_we(1'b0), .m1_addr(8'h00), .m1_wdata(8'h00),
        .m1_gnt(b_g1), .m1_rdata(b_rd1), .m1_rvalid(b_v1),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we),
        .mem_rdata(8'h00), .owner(b_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: contents i+1, except 0x10 holds 0xA5
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
            mem[8'h10] <= 8'hA5;
            mem_init   <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the hand-derived outputs for that cycle
    task automatic cyc(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                       input logic [1:0] eown, input logic ev0, input logic ev1,
                       input logic [7:0] erd, input bit mid_reset = 1'b0);
        exp_t e;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        e.own   = eown;
        e.g0    = (eown == OWNER_M0);
        e.g1    = (eown == OWNER_M1);
        e.v0    = ev0;
        e.v1    = ev1;
        e.addr  = e.g0 ? a0 : (e.g1 ? a1 : 8'h00);
        e.wdata = e.g0 ? d0 : (e.g1 ? d1 : 8'h00);
        e.we    = e.g0 ? (r0 && w0) : (e.g1 ? (r1 && w1) : 1'b0);
        e.bown  = exp_bown;
        exp_q.push_back(e);
        if (ev0) rd0_q.push_back(erd);
        if (ev1) rd1_q.push_back(erd);
        if (mid_reset) begin
            @(negedge clk);
            #1 reset = 1'b0;
            #1;
            chk("rst_async_m0_gnt", 8'(m0_gnt), 8'h00);
            chk("rst_async_owner", 8'(owner), 8'h00);
            chk("rst_async_mem_addr", mem_addr, 8'h00);
            chk("rst_async_m0_rvalid", 8'(m0_rvalid), 8'h00);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every cycle's outputs and the read data on each rvalid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("owner", 8'(owner), 8'(e.own));
                chk("m0_gnt", 8'(m0_gnt), 8'(e.g0));
                chk("m1_gnt", 8'(m1_gnt), 8'(e.g1));
                chk("m0_rvalid", 8'(m0_rvalid), 8'(e.v0));
                chk("m1_rvalid", 8'(m1_rvalid), 8'(e.v1));
                chk("mem_we", 8'(mem_we), 8'(e.we));
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_wdata", mem_wdata, e.wdata);
                chk("h1_owner", 8'(b_owner), 8'(e.bown));
            end
            if (m0_rvalid) begin
                if (rd0_q.size() == 0) chk("m0_rvalid_unexpected", 8'h01, 8'h00);
                else chk("m0_rdata", m0_rdata, rd0_q.pop_front());
            end
            if (m1_rvalid) begin
                if (rd1_q.size() == 0) chk("m1_rvalid_unexpected", 8'h01, 8'h00);
                else chk("m1_rdata", m1_rdata, rd1_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] own;
        logic       v0, v1;
        n_checks = 0;
        n_fail   = 0;
        exp_bown = OWNER_IDLE;
        reset = 1'b0;
        b_r0 = 1'b0; b_r1 = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        @(posedge clk);
        #1;

        // 1. Reset held with random inputs: everything stays zero
        for (int i = 0; i < 4; i++) begin
            b_r0 = 1'($urandom); b_r1 = 1'($urandom);
            cyc(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                OWNER_IDLE, 1'b0, 1'b0, 8'h00);
            chk("rst_m0_rdata", m0_rdata, 8'h00);
            chk("rst_m1_rdata", m1_rdata, 8'h00);
        end
        b_r0 = 1'b0; b_r1 = 1'b0;
        reset = 1'b1;
        repeat (2) cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);

        // 2. m0 read of 0x10 -> 0xA5 two cycles after req rises
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_M0, 0, 0, 8'h00);
        cyc(0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_M0, 1, 0, 8'hA5);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);

        // 3. m1 write 0x3C to 0x80 (no rvalid), then read it back
        cyc(0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 8'h3C, OWNER_IDLE, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 8'h3C, OWNER_M1, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 8'h00, 0, 1, 8'h80, 8'h3C, OWNER_M1, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h80, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h80, 8'h00, OWNER_M1, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h80, 8'h00, OWNER_M1, 0, 1, 8'h3C);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);

        // 4. Both masters contend: M0 x4, M1 x4, M0 x4 with no idle gap
        for (int i = 0; i <= 12; i++) begin
            own = (i == 0) ? OWNER_IDLE : ((i <= 4 || i >= 9) ? OWNER_M0 : OWNER_M1);
            v0  = (i >= 2 && i <= 5) || (i >= 10);
            v1  = (i >= 6 && i <= 9);
            cyc(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, own, v0, v1, v0 ? 8'h02 : 8'h03);
        end
        cyc(0, 0, 8'h01, 8'h00, 0, 0, 8'h02, 8'h00, OWNER_M1, 1, 0, 8'h02);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);

        // 5. M0 releases after 2 transfers; M1 then gets a full hold of 4
        cyc(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        cyc(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, OWNER_M0, 0, 0, 8'h00);
        cyc(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, OWNER_M0, 1, 0, 8'h02);
        cyc(0, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, OWNER_M0, 1, 0, 8'h02);
        for (int i = 4; i <= 7; i++)
            cyc(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, OWNER_M1, 0, (i >= 5), 8'h03);
        cyc(0, 0, 8'h01, 8'h00, 0, 0, 8'h02, 8'h00, OWNER_M0, 0, 1, 8'h03);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);

        // 6. Reset during a read transfer cancels rvalid and restores the tie pointer
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_M0, 0, 0, 8'h00, 1'b1);
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        chk("rst_mid_m0_rdata", m0_rdata, 8'h00);
        chk("rst_mid_m1_rdata", m1_rdata, 8'h00);
        reset = 1'b1;
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        cyc(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        cyc(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, OWNER_M0, 0, 0, 8'h00);
        cyc(0, 0, 8'h20, 8'h00, 0, 0, 8'h21, 8'h00, OWNER_M0, 1, 0, 8'h21);
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);

        // 4b. MAX_HOLD=1 instance: grant alternates every cycle under contention
        for (int i = 0; i <= 8; i++) begin
            b_r0 = 1'b1; b_r1 = 1'b1;
            exp_bown = (i == 0) ? OWNER_IDLE : ((i % 2 == 1) ? OWNER_M0 : OWNER_M1);
            cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        end
        b_r0 = 1'b0; b_r1 = 1'b0;
        exp_bown = OWNER_M0;
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);
        exp_bown = OWNER_IDLE;
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, OWNER_IDLE, 0, 0, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("exp_q_drained", 8'(exp_q.size()), 8'h00);
        chk("rd0_q_drained", 8'(rd0_q.size()), 8'h00);
        chk("rd1_q_drained", 8'(rd1_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
